impact_sram_ctrl: RTL and testbench
===================================

IMPACT_SRAM_CTRL -- requirements
Module: impact_sram_ctrl

Interface
REQ-001 SHALL have parameter PRE_CYCLES, default 2, precharge phase length in clocks (legal 1..15; 0 is treated as 1).
REQ-002 SHALL have parameter ACC_CYCLES, default 2, wordline/access phase length in clocks (legal 1..15; 0 is treated as 1).
REQ-003 SHALL have port wb_clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  request present.
REQ-006 SHALL have port req_ready  out  1  controller can accept a request.
REQ-007 SHALL have port req_we  in  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  in  10  word address 0..1023.
REQ-009 SHALL have port req_wdata  in  32  write data.
REQ-010 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  out  32  read data.
REQ-012 SHALL have port sram_addr  out  10  address to the bank word decoder.
REQ-013 SHALL have port sram_wl_en  out  1  wordline-decoder enable.
REQ-014 SHALL have port sram_pre  out  1  bitline precharge, active-high.
REQ-015 SHALL have port sram_read_en  out  1  bank ReadEn.
REQ-016 SHALL have port sram_write_en  out  1  bank WriteEn.
REQ-017 SHALL have port sram_din  out  32  bank DataIn.
REQ-018 SHALL have port sram_dout  in  32  bank DataOut.

Function
REQ-019 SHALL implement FSM states IDLE, PRE, ACC, DONE.
REQ-020 SHALL drive req_ready = 1 only in IDLE; a handshake is req_valid & req_ready at a rising edge.
REQ-021 On handshake SHALL latch req_we, req_addr and req_wdata and go IDLE->PRE; req_valid without req_ready is ignored, and nothing is queued.
REQ-022 In PRE SHALL hold sram_pre = 1 for exactly PRE_CYCLES clocks, then go to ACC.
REQ-023 In ACC SHALL hold sram_wl_en = 1 and either sram_read_en or sram_write_en = 1 (per latched we) for exactly ACC_CYCLES clocks, then go to DONE.
REQ-024 In DONE SHALL assert rsp_valid = 1 for exactly one clock, for both reads and writes, then go to IDLE.
REQ-025 For reads SHALL capture sram_dout into rsp_rdata at the edge ending the last ACC cycle; rsp_rdata holds until the next read capture, and writes leave it unchanged.
REQ-026 SHALL give latency from handshake edge to rsp_valid high of PRE_CYCLES+ACC_CYCLES+1 clocks; minimum request spacing is PRE_CYCLES+ACC_CYCLES+2 clocks.
REQ-027 SHALL drive sram_addr and sram_din from the latched values, stable throughout PRE and ACC, and holding their last value in IDLE/DONE.
REQ-028 SHALL guarantee sram_pre is never high together with sram_wl_en, sram_read_en or sram_write_en.
REQ-029 SHALL guarantee sram_read_en and sram_write_en are never both high.
REQ-030 SHALL drive sram_wl_en, sram_read_en and sram_write_en low in IDLE, PRE and DONE.
REQ-031 SHALL use a 4-bit phase counter, reloaded at each phase entry, with no wrap beyond the programmed length.
REQ-032 SHALL treat address 1023 and address 0 as normal addresses, with no special handling.

Reset
REQ-033 SHALL, while wb_rst_i = 1, immediately force FSM = IDLE, counter = 0, and sram_addr, sram_din, rsp_rdata = 0.
REQ-034 SHALL, while wb_rst_i = 1, force sram_pre, sram_wl_en, sram_read_en, sram_write_en, rsp_valid = 0 and req_ready = 0.
REQ-035 SHALL raise req_ready at the first rising edge after wb_rst_i deasserts.
REQ-036 SHALL abort any transaction in progress on reset, with no rsp_valid for it, and SHALL drop strobes asynchronously rather than waiting for a clock edge.

Verification
REQ-037 Write then read: write addr 0x3FF, data 0xDEADBEEF with defaults -> sram_write_en high 2 clocks, rsp_valid at +5; read 0x3FF with the bank model returning 0xDEADBEEF -> rsp_rdata = 0xDEADBEEF at +5.
REQ-038 Back-to-back: req_valid held high with 3 reads -> handshakes 6 clocks apart; req_ready low while busy, with no lost or duplicated rsp_valid.
REQ-039 Parameters: PRE_CYCLES=1, ACC_CYCLES=4 -> sram_pre 1 clock, sram_read_en 4 clocks, latency 6; PRE_CYCLES=0 behaves as 1.
REQ-040 Reset mid-ACC: assert wb_rst_i during the 2nd ACC cycle -> all strobes low before the next edge, no rsp_valid, and req_ready = 1 one edge after release.
REQ-041 Invariants: with random traffic for 10k cycles, assertions for REQ-028/029/027 never fire, and a write followed by a read to the same address returns the written data.

Source files
------------

// File: rtl/impact_sram_ctrl.sv
// impact_sram_ctrl: single-port SRAM bank sequencer.
// Runs precharge and access phases, then returns a one-cycle completion pulse.
module impact_sram_ctrl #(
  parameter int unsigned PRE_CYCLES = 2,
  parameter int unsigned ACC_CYCLES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [9:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [9:0]  sram_addr,
  output logic        sram_wl_en,
  output logic        sram_pre,
  output logic        sram_read_en,
  output logic        sram_write_en,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout
);

  // A zero length means one clock; lengths above 15 saturate.
  localparam int unsigned PRE_N =
    (PRE_CYCLES == 0) ? 1 : (PRE_CYCLES > 15) ? 15 : PRE_CYCLES;
  localparam int unsigned ACC_N =
    (ACC_CYCLES == 0) ? 1 : (ACC_CYCLES > 15) ? 15 : ACC_CYCLES;

  // Counter holds remaining clocks minus one in the current phase.
  localparam logic [3:0] PRE_LD = 4'(PRE_N - 1);
  localparam logic [3:0] ACC_LD = 4'(ACC_N - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    ACC,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;
  logic        init_q;
  logic        we_q;
  logic        hs;
  logic        last;
  logic        cap;

  assign hs   = req_valid & req_ready;
  assign last = (cnt == 4'd0);
  assign cap  = (state == ACC) & last & ~we_q;

  // State and phase counter; reset drops back to IDLE at once.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Holds req_ready low until the first edge after reset release.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      init_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
    end
  end

  // Next-state and counter reload at each phase entry.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (hs) begin
          state_nx = PRE;
          cnt_nx   = PRE_LD;
        end
      end
      PRE: begin
        if (last) begin
          state_nx = ACC;
          cnt_nx   = ACC_LD;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ACC: begin
        if (last) begin
          state_nx = DONE;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // Request capture; address and data stay put until the next handshake.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      we_q      <= 1'b0;
      sram_addr <= 10'd0;
      sram_din  <= 32'd0;
    end else if (hs) begin
      we_q      <= req_we;
      sram_addr <= req_addr;
      sram_din  <= req_wdata;
    end
  end

  // Read data is sampled on the edge that closes the access phase.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rsp_rdata <= 32'd0;
    end else if (cap) begin
      rsp_rdata <= sram_dout;
    end
  end

  // Strobes decode from state only, so they can never overlap.
  always_comb begin
    req_ready     = (state == IDLE) & init_q;
    sram_pre      = (state == PRE);
    sram_wl_en    = (state == ACC);
    sram_read_en  = (state == ACC) & ~we_q;
    sram_write_en = (state == ACC) & we_q;
    rsp_valid     = (state == DONE);
  end

endmodule

// File: tb/tb_impact_sram_ctrl.sv
// tb_impact_sram_ctrl: vector table, scoreboard and corner sequences
// for impact_sram_ctrl at default and non-default phase lengths.
module tb_impact_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        rq_we;
  logic [9:0]  rq_addr;
  logic [31:0] rq_wdata;

  logic        vld[3];
  logic        rdy[3];
  logic        rv[3];
  logic [31:0] rd[3];
  logic [9:0]  sa[3];
  logic        wl[3];
  logic        pre[3];
  logic        rde[3];
  logic        wre[3];
  logic [31:0] sd[3];
  logic [31:0] dout[3];

  logic [31:0] mem[1024];
  logic [31:0] ref_mem[1024];
  logic        minit;
  logic [31:0] q[$];
  logic [31:0] last_rd;

  int checks;
  int failures;
  int cyc;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          lat;
  } vec_t;

  vec_t tbl[12];

  impact_sram_ctrl u_d0 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_we(rq_we), .req_addr(rq_addr), .req_wdata(rq_wdata),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]),
    .sram_addr(sa[0]), .sram_wl_en(wl[0]), .sram_pre(pre[0]),
    .sram_read_en(rde[0]), .sram_write_en(wre[0]),
    .sram_din(sd[0]), .sram_dout(dout[0])
  );

  impact_sram_ctrl #(.PRE_CYCLES(1), .ACC_CYCLES(4)) u_d1 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_we(rq_we), .req_addr(rq_addr), .req_wdata(rq_wdata),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]),
    .sram_addr(sa[1]), .sram_wl_en(wl[1]), .sram_pre(pre[1]),
    .sram_read_en(rde[1]), .sram_write_en(wre[1]),
    .sram_din(sd[1]), .sram_dout(dout[1])
  );

  impact_sram_ctrl #(.PRE_CYCLES(0), .ACC_CYCLES(2)) u_d2 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(vld[2]), .req_ready(rdy[2]),
    .req_we(rq_we), .req_addr(rq_addr), .req_wdata(rq_wdata),
    .rsp_valid(rv[2]), .rsp_rdata(rd[2]),
    .sram_addr(sa[2]), .sram_wl_en(wl[2]), .sram_pre(pre[2]),
    .sram_read_en(rde[2]), .sram_write_en(wre[2]),
    .sram_din(sd[2]), .sram_dout(dout[2])
  );

  function automatic logic [31:0] init_val(input logic [9:0] a);
    return 32'hA5C30000 | {22'd0, a};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bank model: only the default instance writes it.
  always @(posedge clk) begin
    if (minit !== 1'b1) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(10'(i));
      minit <= 1'b1;
    end else if (wre[0]) begin
      mem[sa[0]] <= sd[0];
    end
  end

  assign dout[0] = mem[sa[0]];
  assign dout[1] = mem[sa[1]];
  assign dout[2] = mem[sa[2]];

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endfunction

  function automatic void push(input logic w,
                               input logic [9:0] a,
                               input logic [31:0] d);
    if (w) begin
      ref_mem[a] = d;
    end else begin
      last_rd = ref_mem[a];
    end
    q.push_back(last_rd);
  endfunction

  // Pops one expected response per completion pulse.
  always @(negedge clk) begin
    if (!rst && rv[0] === 1'b1) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        chk("rsp_rdata", rd[0], q.pop_front());
      end
    end
  end

  logic        pb[3];
  logic [9:0]  pa[3];
  logic [31:0] pd[3];

  // Strobe exclusivity and address/data stability every cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        pb[k] = 1'b0;
      end else begin
        chk("inv_pre_ovl", {31'd0, pre[k] & (wl[k] | rde[k] | wre[k])}, 32'd0);
        chk("inv_rw_ovl", {31'd0, rde[k] & wre[k]}, 32'd0);
        if ((pre[k] | wl[k]) && pb[k]) begin
          chk("inv_addr_stable", {22'd0, sa[k]}, {22'd0, pa[k]});
          chk("inv_din_stable", sd[k], pd[k]);
        end
        pb[k] = pre[k] | wl[k];
        pa[k] = sa[k];
        pd[k] = sd[k];
      end
    end
  end

  task automatic do_req(input int k, input logic w,
                        input logic [9:0] a, input logic [31:0] d,
                        output int lat, output int np,
                        output int nr, output int nw);
    int t;
    lat = 0; np = 0; nr = 0; nw = 0;
    @(negedge clk);
    rq_we = w; rq_addr = a; rq_wdata = d;
    vld[k] = 1'b1;
    t = 0;
    while (rdy[k] !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (rdy[k] !== 1'b1) begin
      chk("hs_timeout", 32'd1, 32'd0);
      vld[k] = 1'b0;
      return;
    end
    if (k == 0) push(w, a, d);
    @(posedge clk);
    #1;
    vld[k] = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (pre[k]) np++;
      if (wl[k] & rde[k]) nr++;
      if (wl[k] & wre[k]) nw++;
    end while (rv[k] !== 1'b1 && lat < 40);
    if (rv[k] !== 1'b1) chk("rsp_timeout", 32'd1, 32'd0);
  endtask

  task automatic chk_idle_reset(input int k);
    chk("rst_ready", {31'd0, rdy[k]}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rv[k]}, 32'd0);
    chk("rst_strobes", {28'd0, pre[k], wl[k], rde[k], wre[k]}, 32'd0);
    chk("rst_addr", {22'd0, sa[k]}, 32'd0);
    chk("rst_din", sd[k], 32'd0);
    chk("rst_rdata", rd[k], 32'd0);
  endtask

  int lat, np, nr, nw;
  int hs_cyc[3];
  int t;
  logic [9:0] b2b[3];

  initial begin
    checks = 0; failures = 0; cyc = 0;
    last_rd = 32'd0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(10'(i));
    for (int k = 0; k < 3; k++) vld[k] = 1'b0;
    rq_we = 1'b0; rq_addr = 10'd0; rq_wdata = 32'd0;

    tbl[0]  = '{1'b1, 10'h3FF, 32'hDEADBEEF, 5};
    tbl[1]  = '{1'b0, 10'h3FF, 32'h0, 5};
    tbl[2]  = '{1'b1, 10'h000, 32'h12345678, 5};
    tbl[3]  = '{1'b0, 10'h000, 32'h0, 5};
    tbl[4]  = '{1'b0, 10'h3FF, 32'h0, 5};
    tbl[5]  = '{1'b1, 10'h2AA, 32'hCAFEF00D, 5};
    tbl[6]  = '{1'b1, 10'h000, 32'hFFFFFFFF, 5};
    tbl[7]  = '{1'b0, 10'h2AA, 32'h0, 5};
    tbl[8]  = '{1'b0, 10'h000, 32'h0, 5};
    tbl[9]  = '{1'b0, 10'h100, 32'h0, 5};
    tbl[10] = '{1'b1, 10'h3FF, 32'h00000000, 5};
    tbl[11] = '{1'b0, 10'h3FF, 32'h0, 5};

    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk_idle_reset(k);
    rst = 1'b0;
    #1;
    chk("ready_before_edge", {31'd0, rdy[0]}, 32'd0);
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk("ready_after_edge", {31'd0, rdy[k]}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      do_req(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, np, nr, nw);
      chk("tbl_latency", 32'(lat), 32'(tbl[i].lat));
      chk("tbl_pre_cycles", 32'(np), 32'd2);
      chk("tbl_read_cycles", 32'(nr), tbl[i].we ? 32'd0 : 32'd2);
      chk("tbl_write_cycles", 32'(nw), tbl[i].we ? 32'd2 : 32'd0);
    end

    b2b[0] = 10'h3FF; b2b[1] = 10'h000; b2b[2] = 10'h200;
    @(negedge clk);
    rq_we = 1'b0; rq_addr = b2b[0];
    vld[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t = 0;
      while (rdy[0] !== 1'b1 && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (rdy[0] !== 1'b1) chk("b2b_hs_timeout", 32'd1, 32'd0);
      hs_cyc[i] = cyc;
      push(1'b0, b2b[i], 32'd0);
      @(posedge clk);
      #1;
      if (i < 2) rq_addr = b2b[i + 1];
      @(negedge clk);
      chk("b2b_ready_busy", {31'd0, rdy[0]}, 32'd0);
    end
    vld[0] = 1'b0;
    t = 0;
    while (q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("b2b_gap1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd6);
    chk("b2b_gap2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd6);
    chk("b2b_drained", 32'(q.size()), 32'd0);

    do_req(1, 1'b0, 10'h155, 32'h0, lat, np, nr, nw);
    chk("p14_latency", 32'(lat), 32'd6);
    chk("p14_pre_cycles", 32'(np), 32'd1);
    chk("p14_read_cycles", 32'(nr), 32'd4);
    chk("p14_rdata", rd[1], init_val(10'h155));

    do_req(2, 1'b0, 10'h0AA, 32'h0, lat, np, nr, nw);
    chk("p02_latency", 32'(lat), 32'd4);
    chk("p02_pre_cycles", 32'(np), 32'd1);
    chk("p02_read_cycles", 32'(nr), 32'd2);
    chk("p02_rdata", rd[2], init_val(10'h0AA));

    @(negedge clk);
    rq_we = 1'b1; rq_addr = 10'h0F0; rq_wdata = 32'h0BADF00D;
    vld[0] = 1'b1;
    t = 0;
    while (rdy[0] !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_acc_wl", {31'd0, wl[0]}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_strobes",
        {27'd0, pre[0], wl[0], rde[0], wre[0], rv[0]}, 32'd0);
    chk("mid_rst_ready", {31'd0, rdy[0]}, 32'd0);
    q.delete();
    last_rd = 32'd0;
    @(posedge clk);
    @(negedge clk);
    chk_idle_reset(0);
    rst = 1'b0;
    #1;
    chk("mid_ready_before_edge", {31'd0, rdy[0]}, 32'd0);
    @(negedge clk);
    chk("mid_ready_after_edge", {31'd0, rdy[0]}, 32'd1);
    repeat (8) @(negedge clk);

    for (int i = 0; i < 1500; i++) begin
      do_req(0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
             $urandom, lat, np, nr, nw);
      if (lat != 5) chk("rnd_latency", 32'(lat), 32'd5);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
